// File: rtl/sram_capture_pkg.sv
// Shared constants, FSM encoding and alta_ram4k configuration for the sample-capture block.
package sram_capture_pkg;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;
  localparam int DATA_W = 8;
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } state_e;

  // alta_ram4k configuration: 512x8, single clock, unregistered output
  localparam string RAM_CLKMODE         = "read_write";
  localparam int    RAM_DATA_WIDTH      = 8;
  localparam int    RAM_ADDR_WIDTH      = 9;
  localparam string RAM_PORTA_WRITEMODE = "normal";
  localparam string RAM_PORTA_OUTREG    = "no";
endpackage

// File: rtl/sram_512x8.sv
// 512x8 single-port RAM, 1-cycle read latency. Define ALTA_RAM4K_PRIMITIVE to map onto
// the vendor alta_ram4k block (port B tied off); otherwise an equivalent inferred array is used.
module sram_512x8
  import sram_capture_pkg::*;
(
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  output logic [DATA_W-1:0] dout
);
`ifdef ALTA_RAM4K_PRIMITIVE
  logic [17:0] douta_w;
  logic [17:0] doutb_w;

  alta_ram4k #(
    .CLKMODE        (RAM_CLKMODE),
    .PORTA_WIDTH    (RAM_DATA_WIDTH),
    .PORTB_WIDTH    (RAM_DATA_WIDTH),
    .PORTA_WRITEMODE(RAM_PORTA_WRITEMODE),
    .PORTA_OUTREG   (RAM_PORTA_OUTREG)
  ) u_ram (
    .Clk0       (clk),
    .ClkEn0     (1'b1),
    .AsyncReset0(1'b0),
    .Clk1       (clk),
    .ClkEn1     (1'b0),
    .AsyncReset1(1'b0),
    .AddressA   ({3'b000, addr}),
    .DataInA    ({10'd0, din}),
    .WeRenA     (we),
    .DataOutA   (douta_w),
    .AddressB   (12'd0),
    .DataInB    (18'd0),
    .WeRenB     (1'b0),
    .DataOutB   (doutb_w)
  );
  assign dout = douta_w[DATA_W-1:0];
`else
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= din;
    dout <= mem[addr];
  end
`endif
endmodule

// File: rtl/sram_capture.sv
// Handshaked byte capture into a 512x8 RAM, then frozen random-access readback.
// Define SRAM_CAPTURE_WRAP_EN for a circular pre-trigger buffer that only stop can end.
module sram_capture
  import sram_capture_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);
  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   oldest_q, oldest_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                accept;
  logic [ADDR_W-1:0]   ram_addr;
  logic [DATA_W-1:0]   ram_dout;

  assign accept = (state_q == CAPTURE) && in_valid;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    count_d   = count_q;
    oldest_d  = oldest_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = CAPTURE;
          wr_addr_d = '0;
          count_d   = '0;
          oldest_d  = '0;
        end
      end
      CAPTURE: begin
        if (accept) begin
          wr_addr_d = wr_addr_q + 1'b1;
          count_d   = (count_q == CNT_W'(DEPTH)) ? count_q : count_q + 1'b1;
        end
`ifdef SRAM_CAPTURE_WRAP_EN
        if (stop) begin
          state_d  = DONE;
          // once the ring has filled, the next write slot holds the oldest sample
          oldest_d = (count_d == CNT_W'(DEPTH)) ? wr_addr_d : '0;
        end
`else
        if (stop || (accept && count_q == CNT_W'(DEPTH - 1))) state_d = DONE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM port A: writer owns it while capturing, reader once frozen
  assign ram_addr = (state_q == DONE) ? ADDR_W'(oldest_q + rd_addr) : wr_addr_q;

  always_comb begin
    rd_data_d  = (state_q == DONE) ? ram_dout : rd_data_q;
    rd_valid_d = (state_q == DONE) && (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      wr_addr_q  <= '0;
      oldest_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_addr_q  <= wr_addr_d;
      oldest_q   <= oldest_d;
      count_q    <= count_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  sram_512x8 u_ram (
    .clk (clk),
    .addr(ram_addr),
    .din (in_data),
    .we  (accept),
    .dout(ram_dout)
  );

  assign in_ready = (state_q == CAPTURE);
  assign busy     = (state_q == CAPTURE);
  assign done     = (state_q == DONE);
  assign count    = count_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
endmodule

// File: tb/tb_sram_capture.sv
// Scenario bench for sram_capture: bench-side model of accepted bytes feeds a readback scoreboard.
module tb_sram_capture;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready, busy, done, rd_valid;
  logic [9:0] count;
  logic [8:0] rd_addr = '0;
  logic [7:0] rd_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] model[$];   // accepted bytes, oldest first
  int         req_addr[$];
  logic [7:0] req_exp[$];
  logic [7:0] sb_q[$];

  sram_capture dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .busy(busy), .done(done), .count(count),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start;
    start = 1'b1;
    model.delete();
    tick();
    start = 1'b0;
  endtask

  task automatic do_stop;
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic feed(input int n, input int base, output int first_low);
    first_low = -1;
    for (int i = 0; i < n; i++) begin
      in_data  = 8'(base + i);
      in_valid = 1'b1;
      if (in_ready) begin
        model.push_back(in_data);
        if (model.size() > 512) void'(model.pop_front());
      end else if (first_low < 0) first_low = i;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_reads(input string name);
    int n;
    logic [7:0] e;
    n = req_addr.size();
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        rd_addr = 9'(req_addr[i]);
        sb_q.push_back(req_exp[i]);
      end
      tick();
      if (i >= 1) begin
        e = sb_q.pop_front();
        n_tests++;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
          n_fail++;
          $display("FAIL %s rd[%0d] got data=%02h valid=%b want data=%02h valid=1",
                   name, req_addr[i-1], rd_data, rd_valid, e);
        end
      end
    end
    req_addr.delete();
    req_exp.delete();
  endtask

  task automatic queue_model_reads(input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      req_addr.push_back(i);
      req_exp.push_back(model[i]);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick(); tick();
    n_tests++;
    if ({in_ready, busy, done, rd_valid, count, rd_data} !== 22'd0) begin
      n_fail++;
      $display("FAIL reset outputs got rdy=%b busy=%b done=%b rv=%b cnt=%0d rd=%02h want all 0",
               in_ready, busy, done, rd_valid, count, rd_data);
    end
    rst = 1'b1;
    tick();
    stop = 1'b1; tick(); stop = 1'b0;
    n_tests++;
    if ({busy, done} !== 2'b00) begin
      n_fail++;
      $display("FAIL idle_stop got busy=%b done=%b want 0 0", busy, done);
    end
  endtask

  task automatic test_basic;
    int fl;
    do_start();
    n_tests++;
    if ({in_ready, busy, done, count} !== {3'b110, 10'd0}) begin
      n_fail++;
      $display("FAIL basic_start got rdy=%b busy=%b done=%b cnt=%0d want 1 1 0 0",
               in_ready, busy, done, count);
    end
    feed(10, 0, fl);
    do_stop();
    n_tests++;
    if ({done, busy, in_ready, rd_valid, count} !== {4'b1000, 10'd10}) begin
      n_fail++;
      $display("FAIL basic_done got done=%b busy=%b rdy=%b rv=%b cnt=%0d want 1 0 0 0 10",
               done, busy, in_ready, rd_valid, count);
    end
    for (int i = 0; i < 10; i++) begin
      req_addr.push_back(i);
      req_exp.push_back(8'(i));
    end
    run_reads("basic_read");
  endtask

  task automatic test_stop_empty;
    do_start();
    do_stop();
    n_tests++;
    if ({done, count} !== {1'b1, 10'd0}) begin
      n_fail++;
      $display("FAIL stop_empty got done=%b cnt=%0d want 1 0", done, count);
    end
  endtask

  task automatic test_stop_coincident;
    int fl;
    do_start();
    feed(3, 8'h10, fl);
    in_data = 8'hA5; in_valid = 1'b1; stop = 1'b1;
    model.push_back(8'hA5);
    tick();
    in_valid = 1'b0; stop = 1'b0;
    n_tests++;
    if ({done, count} !== {1'b1, 10'd4}) begin
      n_fail++;
      $display("FAIL stop_coincident got done=%b cnt=%0d want 1 4", done, count);
    end
    req_addr.push_back(3); req_exp.push_back(8'hA5);
    req_addr.push_back(0); req_exp.push_back(8'h10);
    req_addr.push_back(2); req_exp.push_back(8'h12);
    run_reads("coincident_read");
  endtask

  task automatic test_toggle;
    do_start();
    n_tests++;
    if ({busy, done, rd_valid} !== 3'b100) begin
      n_fail++;
      $display("FAIL restart got busy=%b done=%b rv=%b want 1 0 0", busy, done, rd_valid);
    end
    for (int i = 0; i < 16; i++) begin
      in_valid = (i % 2 == 0);
      in_data  = in_valid ? 8'(8'h40 + i) : 8'hEE;
      if (in_valid && in_ready) model.push_back(in_data);
      tick();
    end
    in_valid = 1'b0;
    do_stop();
    n_tests++;
    if (count !== 10'd8 || model.size() != 8) begin
      n_fail++;
      $display("FAIL toggle_count got cnt=%0d model=%0d want 8", count, model.size());
    end
    queue_model_reads(0, 8);
    run_reads("toggle_read");
  endtask

`ifdef SRAM_CAPTURE_WRAP_EN
  task automatic test_wrap;
    int fl;
    do_start();
    feed(700, 0, fl);
    n_tests++;
    if (fl != -1 || busy !== 1'b1 || count !== 10'd512) begin
      n_fail++;
      $display("FAIL wrap_capture got first_low=%0d busy=%b cnt=%0d want -1 1 512", fl, busy, count);
    end
    do_stop();
    n_tests++;
    if ({done, count} !== {1'b1, 10'd512}) begin
      n_fail++;
      $display("FAIL wrap_done got done=%b cnt=%0d want 1 512", done, count);
    end
    req_addr.push_back(0);   req_exp.push_back(8'hBC);
    req_addr.push_back(511); req_exp.push_back(8'hBB);
    run_reads("wrap_ends");
    queue_model_reads(320, 8);
    run_reads("wrap_mid");
  endtask
`else
  task automatic test_full;
    int fl;
    do_start();
    feed(600, 0, fl);
    n_tests++;
    if (fl != 512 || model.size() != 512) begin
      n_fail++;
      $display("FAIL full_ready got first_low=%0d accepted=%0d want 512 512", fl, model.size());
    end
    n_tests++;
    if ({done, in_ready, count} !== {2'b10, 10'd512}) begin
      n_fail++;
      $display("FAIL full_done got done=%b rdy=%b cnt=%0d want 1 0 512", done, in_ready, count);
    end
    req_addr.push_back(511); req_exp.push_back(8'hFF);
    req_addr.push_back(0);   req_exp.push_back(8'h00);
    req_addr.push_back(300); req_exp.push_back(8'd44);
    run_reads("full_read");
  endtask
`endif

  task automatic test_reset_mid;
    int fl;
    do_start();
    feed(100, 8'h20, fl);
    n_tests++;
    if (count !== 10'd100) begin
      n_fail++;
      $display("FAIL mid_count got %0d want 100", count);
    end
    #2 rst = 1'b0;
    #1;
    n_tests++;
    if ({in_ready, busy, done, rd_valid, count, rd_data} !== 22'd0) begin
      n_fail++;
      $display("FAIL async_reset got rdy=%b busy=%b done=%b rv=%b cnt=%0d rd=%02h want all 0",
               in_ready, busy, done, rd_valid, count, rd_data);
    end
    #1 rst = 1'b1;
    tick();
    do_start();
    feed(3, 8'h77, fl);
    do_stop();
    n_tests++;
    if ({done, count} !== {1'b1, 10'd3}) begin
      n_fail++;
      $display("FAIL post_reset got done=%b cnt=%0d want 1 3", done, count);
    end
    queue_model_reads(0, 3);
    run_reads("post_reset_read");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stop_empty();
    test_stop_coincident();
    test_toggle();
`ifdef SRAM_CAPTURE_WRAP_EN
    test_wrap();
`else
    test_full();
`endif
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
